// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin front end that funnels two command requesters into one APB master.
// Optional macro APB_ARB_TIMEOUT_EN aborts a transfer that sees no apb_done within 16 XFER cycles.
module apb_req_arbiter #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic          req0_valid,
    input  logic          req0_rw,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic          req1_rw,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          transfer,
    output logic          read_write,
    output logic [AW-1:0] apb_write_paddr,
    output logic [AW-1:0] apb_read_paddr,
    output logic [DW-1:0] apb_write_data,
    input  logic [DW-1:0] apb_read_data_out,
    input  logic          apb_done
);
    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t        state;
    logic          ptr;
    logic          owner;
    logic          gnt0;
    logic          gnt1;
    logic          sel_rw;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          xfer_end;
    logic          xfer_err;

    // ptr names the requester that wins the next tie.
    always_comb begin
        gnt0      = (state == IDLE) && req0_valid && (!req1_valid || !ptr);
        gnt1      = (state == IDLE) && req1_valid && (!req0_valid || ptr);
        sel_rw    = gnt1 ? req1_rw    : req0_rw;
        sel_addr  = gnt1 ? req1_addr  : req0_addr;
        sel_wdata = gnt1 ? req1_wdata : req0_wdata;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

`ifdef APB_ARB_TIMEOUT_EN
    logic [3:0] tmo_cnt;
    logic       err_q;

    // apb_done on the final counted cycle still completes normally.
    assign xfer_err = (state == XFER) && !apb_done && (tmo_cnt == 4'd15);
    assign rsp_err  = err_q;

    always_ff @(posedge pclk) begin
        if (preset) begin
            tmo_cnt <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            if (gnt0 || gnt1)
                tmo_cnt <= 4'd0;
            else if (state == XFER)
                tmo_cnt <= tmo_cnt + 4'd1;

            if (xfer_end)
                err_q <= xfer_err;
            else if (state == RESP)
                err_q <= 1'b0;
        end
    end
`else
    assign xfer_err = 1'b0;
    assign rsp_err  = 1'b0;
`endif

    assign xfer_end = (state == XFER) && (apb_done || xfer_err);

    always_ff @(posedge pclk) begin
        if (preset) begin
            state           <= IDLE;
            ptr             <= 1'b0;
            owner           <= 1'b0;
            transfer        <= 1'b0;
            read_write      <= 1'b0;
            apb_write_paddr <= '0;
            apb_read_paddr  <= '0;
            apb_write_data  <= '0;
            rsp0_valid      <= 1'b0;
            rsp1_valid      <= 1'b0;
            rsp_rdata       <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        state           <= XFER;
                        owner           <= gnt1;
                        ptr             <= gnt0;
                        transfer        <= 1'b1;
                        read_write      <= sel_rw;
                        apb_write_paddr <= sel_rw ? sel_addr  : '0;
                        apb_read_paddr  <= sel_rw ? '0        : sel_addr;
                        apb_write_data  <= sel_rw ? sel_wdata : '0;
                    end
                end
                XFER: begin
                    if (xfer_end) begin
                        state           <= RESP;
                        transfer        <= 1'b0;
                        read_write      <= 1'b0;
                        apb_write_paddr <= '0;
                        apb_read_paddr  <= '0;
                        apb_write_data  <= '0;
                        rsp0_valid      <= !owner;
                        rsp1_valid      <= owner;
                        // Writes and aborted transfers return zero data.
                        rsp_rdata       <= (apb_done && !read_write) ? apb_read_data_out : '0;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Define APB_ARB_TIMEOUT_EN for both RTL and bench to exercise the timeout build.
module tb_apb_req_arbiter;
    localparam int AW = 9;
    localparam int DW = 8;

    logic          pclk = 1'b0;
    logic          preset = 1'b0;
    logic          req0_valid = 1'b0, req0_rw = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0, req1_rw = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req1_ready;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err, transfer, read_write;
    logic [AW-1:0] apb_write_paddr, apb_read_paddr;
    logic [DW-1:0] apb_write_data;
    logic [DW-1:0] apb_read_data_out = '0;
    logic          apb_done = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int last_gnt = 1;          // model: most recent grant; 1 after reset so req0 wins the first tie
    logic [DW-1:0] exp_rdata = '0;

    apb_req_arbiter #(.AW(AW), .DW(DW)) dut (
        .pclk(pclk), .preset(preset),
        .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .transfer(transfer), .read_write(read_write),
        .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
        .apb_write_data(apb_write_data), .apb_read_data_out(apb_read_data_out),
        .apb_done(apb_done)
    );

    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic apply_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        apb_done   = 1'b0;
        preset     = 1'b1;
        step();
        preset     = 1'b0;
        last_gnt   = 1;
        exp_rdata  = '0;
    endtask

    // One complete command: grant, XFER for lat+1 cycles (done on the last), RESP, back in IDLE.
    task automatic do_txn(input string tag, input logic v0, input logic v1,
                          input logic r0, input logic r1,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input int lat, input logic [DW-1:0] rd, input bit noise);
        int            own;
        logic          rw;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        req0_valid = v0; req0_rw = r0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_rw = r1; req1_addr = a1; req1_wdata = d1;
        #1;
        own = (v0 && v1) ? 1 - last_gnt : (v1 ? 1 : 0);
        rw  = own ? r1 : r0;
        a   = own ? a1 : a0;
        wd  = own ? d1 : d0;
        n_cmp++;
        if (req0_ready !== (own == 0) || req1_ready !== (own == 1)) begin
            n_bad++;
            $display("FAIL %s grant: ready1/0=%b%b want owner %0d", tag, req1_ready, req0_ready, own);
        end
        last_gnt = own;
        step();
        for (int k = 0; k <= lat; k++) begin
            req0_valid = noise ? 1'($urandom) : 1'b0;
            req1_valid = noise ? 1'($urandom) : 1'b0;
            apb_done   = (k == lat);
            apb_read_data_out = (k == lat) ? rd : DW'($urandom);
            #1;
            n_cmp++;
            if (transfer !== 1'b1 || read_write !== rw ||
                apb_write_paddr !== (rw ? a : {AW{1'b0}}) ||
                apb_read_paddr  !== (rw ? {AW{1'b0}} : a) ||
                apb_write_data  !== (rw ? wd : {DW{1'b0}})) begin
                n_bad++;
                $display("FAIL %s xfer%0d: xfer=%b rw=%b wa=%h ra=%h wd=%h want rw=%b addr=%h wd=%h",
                         tag, k, transfer, read_write, apb_write_paddr, apb_read_paddr,
                         apb_write_data, rw, a, wd);
            end
            n_cmp++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL %s busy%0d: ready=%b%b rsp=%b%b want all 0", tag, k,
                         req1_ready, req0_ready, rsp1_valid, rsp0_valid);
            end
            step();
        end
        apb_done   = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_rdata  = rw ? {DW{1'b0}} : rd;
        n_cmp++;
        if (rsp0_valid !== (own == 0) || rsp1_valid !== (own == 1) || rsp_err !== 1'b0 ||
            rsp_rdata !== exp_rdata || transfer !== 1'b0) begin
            n_bad++;
            $display("FAIL %s resp: rsp1/0=%b%b err=%b rdata=%h xfer=%b want owner %0d rdata=%h",
                     tag, rsp1_valid, rsp0_valid, rsp_err, rsp_rdata, transfer, own, exp_rdata);
        end
        step();
        n_cmp++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp_rdata !== exp_rdata || transfer !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle: rsp1/0=%b%b rdata=%h xfer=%b want 00 rdata=%h",
                     tag, rsp1_valid, rsp0_valid, rsp_rdata, transfer, exp_rdata);
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        step();
        step();
        n_cmp++;
        if (transfer !== 1'b0 || read_write !== 1'b0 || apb_write_paddr !== '0 || apb_read_paddr !== '0 ||
            apb_write_data !== '0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 ||
            rsp_rdata !== '0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: xfer=%b rw=%b wa=%h ra=%h wd=%h rsp=%b%b rdata=%h err=%b want all 0",
                     transfer, read_write, apb_write_paddr, apb_read_paddr, apb_write_data,
                     rsp1_valid, rsp0_valid, rsp_rdata, rsp_err);
        end
        preset   = 1'b0;
        last_gnt = 1;
        exp_rdata = '0;
    endtask

    task automatic test_single_write();
        do_txn("single_write", 1'b1, 1'b0, 1'b1, 1'b0, 9'h105, 9'h000, 8'hA5, 8'h00, 1, 8'h77, 1'b0);
    endtask

    task automatic test_single_read();
        do_txn("single_read", 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 9'h00C, 8'h00, 8'h00, 0, 8'h3C, 1'b0);
    endtask

    task automatic test_contention();
        apply_reset();
        for (int i = 0; i < 4; i++)
            do_txn($sformatf("contention%0d", i), 1'b1, 1'b1, 1'($urandom), 1'($urandom),
                   AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                   $urandom_range(0, 2), DW'($urandom), 1'b1);
    endtask

    task automatic test_spurious_done();
        apb_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (transfer !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp_rdata !== exp_rdata) begin
                n_bad++;
                $display("FAIL spurious_done%0d: xfer=%b rsp=%b%b rdata=%h want 0 00 %h",
                         i, transfer, rsp1_valid, rsp0_valid, rsp_rdata, exp_rdata);
            end
        end
        apb_done = 1'b0;
        do_txn("after_spurious", 1'b1, 1'b0, 1'b0, 1'b0, 9'h1F0, 9'h000, 8'h00, 8'h00, 0, 8'h5A, 1'b0);
    endtask

    task automatic test_reset_in_xfer();
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 9'h0AA;
        step();
        req0_valid = 1'b0;
        n_cmp++;
        if (transfer !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_xfer_pre: transfer=%b want 1", transfer);
        end
        preset = 1'b1;
        step();
        preset = 1'b0;
        last_gnt = 1;
        exp_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (transfer !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_xfer_post%0d: xfer=%b rsp=%b%b want 0 00", i, transfer, rsp1_valid, rsp0_valid);
            end
            step();
        end
        do_txn("rst_then_req1", 1'b0, 1'b1, 1'b0, 1'b1, 9'h000, 9'h133, 8'h00, 8'hC3, 2, 8'h11, 1'b0);
    endtask

    task automatic test_timeout();
        bit ok;
        do_txn("pre_timeout", 1'b1, 1'b0, 1'b0, 1'b0, 9'h010, 9'h000, 8'h00, 8'h00, 0, 8'h9E, 1'b0);
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 9'h044;
        #1;
        last_gnt = 0;
        step();
        req0_valid = 1'b0;
        ok = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            if (transfer !== 1'b1 || rsp0_valid !== 1'b0) ok = 1'b0;
            step();
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL timeout_wait: transfer dropped or early rsp within 16 XFER cycles");
        end
        n_cmp++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_err !== 1'b1 || rsp_rdata !== '0 || transfer !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_resp: rsp=%b%b err=%b rdata=%h xfer=%b want 01 1 00 0",
                     rsp1_valid, rsp0_valid, rsp_err, rsp_rdata, transfer);
        end
        exp_rdata = '0;
        step();
        n_cmp++;
        if (rsp_err !== 1'b0 || rsp0_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_clear: err=%b rsp0=%b want 0 0", rsp_err, rsp0_valid);
        end
        do_txn("done_at_timeout", 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 9'h055, 8'h00, 8'h00, 15, 8'hE1, 1'b0);
`else
        for (int k = 1; k <= 24; k++) begin
            if (transfer !== 1'b1 || rsp0_valid !== 1'b0 || rsp_err !== 1'b0) ok = 1'b0;
            step();
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL no_timeout: transfer=%b rsp0=%b err=%b want transfer held with no response",
                     transfer, rsp0_valid, rsp_err);
        end
        apply_reset();
`endif
    endtask

    task automatic test_random();
        logic [1:0] v;
        for (int i = 0; i < 40; i++) begin
            v = 2'($urandom_range(1, 3));
            do_txn($sformatf("rand%0d", i), v[0], v[1], 1'($urandom), 1'($urandom),
                   AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                   $urandom_range(0, 5), DW'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                apb_done = 1'($urandom);
                step();
                apb_done = 1'b0;
                n_cmp++;
                if (transfer !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp_rdata !== exp_rdata) begin
                    n_bad++;
                    $display("FAIL rand_gap%0d: xfer=%b rsp=%b%b rdata=%h want 0 00 %h",
                             i, transfer, rsp1_valid, rsp0_valid, rsp_rdata, exp_rdata);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_spurious_done();
        test_reset_in_xfer();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
